// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache in front of the fetch stage.
// Lookup is combinational; a miss fetches one whole line from memory through IDLE -> REQ -> FILL.
module icache_fetch #(
    parameter int unsigned ADDRESS_SIZE = 32,
    parameter logic [ADDRESS_SIZE-1:0] BOOT_ADDRESS = ADDRESS_SIZE'(32'h1000),
    parameter int unsigned LINES = 4,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDRESS_SIZE-1:0]    pc,
    input  logic                       I_stall_in,
    output logic [ADDRESS_SIZE-1:0]    I_instruction,
    output logic                       I_stall,
    output logic                       mem_req,
    output logic [ADDRESS_SIZE-1:0]    mem_addr,
    input  logic                       mem_ready,
    input  logic [32*LINE_WORDS-1:0]   mem_data
);

    localparam int unsigned WORD_BITS   = $clog2(LINE_WORDS);
    localparam int unsigned INDEX_BITS  = $clog2(LINES);
    localparam int unsigned OFFSET_BITS = WORD_BITS + 2;
    localparam int unsigned TAG_LSB     = OFFSET_BITS + INDEX_BITS;
    localparam int unsigned TAG_BITS    = ADDRESS_SIZE - TAG_LSB;

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]         valid_q;
    logic [TAG_BITS-1:0]      tag_mem  [LINES];
    logic [31:0]              data_mem [LINES][LINE_WORDS];
    logic [ADDRESS_SIZE-1:0]  miss_addr;

    logic [WORD_BITS-1:0]     word;
    logic [INDEX_BITS-1:0]    index;
    logic [TAG_BITS-1:0]      tag;
    logic [INDEX_BITS-1:0]    fill_index;
    logic [TAG_BITS-1:0]      fill_tag;
    logic                     hit;
    logic                     fill_en;
    logic                     latch_miss;

    // The byte offset and the boot address carry no logic.
    logic unused_bits;
    assign unused_bits = ^{pc[1:0], BOOT_ADDRESS};

    assign word       = pc[OFFSET_BITS-1:2];
    assign index      = pc[TAG_LSB-1:OFFSET_BITS];
    assign tag        = pc[ADDRESS_SIZE-1:TAG_LSB];
    assign fill_index = miss_addr[TAG_LSB-1:OFFSET_BITS];
    assign fill_tag   = miss_addr[ADDRESS_SIZE-1:TAG_LSB];

    assign hit = (state_q == IDLE) && valid_q[index] && (tag_mem[index] == tag);

    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_addr      = '0;
        fill_en       = 1'b0;
        latch_miss    = 1'b0;
        I_instruction = '0;
        I_stall       = 1'b1;

        if (hit) begin
            I_instruction = ADDRESS_SIZE'(data_mem[index][word]);
            I_stall       = I_stall_in;
        end

        case (state_q)
            IDLE: begin
                if (!hit) begin
                    state_d    = REQ;
                    latch_miss = 1'b1;
                end
            end
            REQ: begin
                mem_req  = 1'b1;
                mem_addr = miss_addr;
                if (mem_ready) begin
                    fill_en = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            miss_addr <= '0;
        end else begin
            state_q <= state_d;
            if (latch_miss) begin
                miss_addr <= {pc[ADDRESS_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            end
            if (fill_en) begin
                valid_q[fill_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays are gated by valid bits, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_index] <= fill_tag;
            for (int k = 0; k < int'(LINE_WORDS); k++) begin
                data_mem[fill_index][k] <= mem_data[32*k +: 32];
            end
        end
    end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: stimulus pushes per-cycle expectations into a
// scoreboard queue, and a negedge monitor pops and compares them.
module tb_icache_fetch;

    logic          clk;
    logic          reset;
    logic [31:0]   pc;
    logic          I_stall_in;
    logic [31:0]   I_instruction;
    logic          I_stall;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ready;
    logic [127:0]  mem_data;

    icache_fetch #(
        .ADDRESS_SIZE(32),
        .BOOT_ADDRESS(32'h1000),
        .LINES(4),
        .LINE_WORDS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pc(pc),
        .I_stall_in(I_stall_in),
        .I_instruction(I_instruction),
        .I_stall(I_stall),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ready(mem_ready),
        .mem_data(mem_data)
    );

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] instr;
        logic        stall;
        logic        req;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] LINE_A = {32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [127:0] LINE_B = {32'ha4, 32'ha3, 32'ha2, 32'ha1};
    localparam logic [127:0] LINE_C = {32'hb4, 32'hb3, 32'hb2, 32'hb1};
    localparam logic [127:0] LINE_D = {32'hc4, 32'hc3, 32'hc2, 32'hc1};
    localparam logic [127:0] JUNK   = {4{32'hdeadbeef}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One cycle of stimulus plus the outputs expected during that cycle.
    task automatic drive(input string name, input logic r, input logic [31:0] p,
                         input logic sin, input logic rdy, input logic [127:0] d,
                         input logic [31:0] e_instr, input logic e_stall,
                         input logic e_req, input logic [31:0] e_addr);
        exp_t e;
        @(posedge clk);
        #1;
        reset      = r;
        pc         = p;
        I_stall_in = sin;
        mem_ready  = rdy;
        mem_data   = d;
        e.cyc   = cyc;
        e.name  = name;
        e.instr = e_instr;
        e.stall = e_stall;
        e.req   = e_req;
        e.addr  = e_addr;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: sampled at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
            end else if (I_instruction !== e.instr || I_stall !== e.stall ||
                         mem_req !== e.req || mem_addr !== e.addr) begin
                errors++;
                $display("FAIL %s: got instr=%h stall=%b req=%b addr=%h, required instr=%h stall=%b req=%b addr=%h",
                         e.name, I_instruction, I_stall, mem_req, mem_addr,
                         e.instr, e.stall, e.req, e.addr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pc = 32'h1000; I_stall_in = 1'b0; mem_ready = 1'b1; mem_data = LINE_A;

        drive("reset0",      1, 32'h1000, 0, 1, LINE_A, 32'h0, 1, 0, 32'h0);
        drive("reset1",      1, 32'h1000, 0, 1, LINE_A, 32'h0, 1, 0, 32'h0);

        // Cold miss with mem_ready arriving in the fifth REQ cycle.
        drive("cold_miss",   0, 32'h1000, 0, 0, '0, 32'h0, 1, 0, 32'h0);
        for (int i = 0; i < 4; i++)
            drive("req_wait", 0, 32'h1000, 0, 0, '0, 32'h0, 1, 1, 32'h1000);
        drive("req_ready",   0, 32'h1000, 0, 1, LINE_A, 32'h0, 1, 1, 32'h1000);
        drive("fill",        0, 32'h1000, 0, 0, '0, 32'h0, 1, 0, 32'h0);
        drive("hit_1000",    0, 32'h1000, 0, 0, '0, 32'h11, 0, 0, 32'h0);
        drive("hit_1004",    0, 32'h1004, 0, 0, '0, 32'h22, 0, 0, 32'h0);
        drive("hit_1008",    0, 32'h1008, 0, 0, '0, 32'h33, 0, 0, 32'h0);
        drive("hit_100c",    0, 32'h100c, 0, 0, '0, 32'h44, 0, 0, 32'h0);

        drive("ds_stall",    0, 32'h1004, 1, 0, '0, 32'h22, 1, 0, 32'h0);
        drive("stray_ready", 0, 32'h1008, 0, 1, JUNK, 32'h33, 0, 0, 32'h0);
        drive("after_stray", 0, 32'h1008, 0, 0, '0, 32'h33, 0, 0, 32'h0);

        // Conflict on index 0; miss detected despite downstream stall, ready in first REQ cycle.
        drive("conf_miss",   0, 32'h1040, 1, 0, '0, 32'h0, 1, 0, 32'h0);
        drive("conf_req",    0, 32'h1040, 0, 1, LINE_B, 32'h0, 1, 1, 32'h1040);
        drive("conf_fill",   0, 32'h1040, 0, 0, '0, 32'h0, 1, 0, 32'h0);
        drive("hit_1040",    0, 32'h1040, 0, 0, '0, 32'ha1, 0, 0, 32'h0);
        drive("hit_104c",    0, 32'h104c, 0, 0, '0, 32'ha4, 0, 0, 32'h0);
        drive("evicted",     0, 32'h1000, 0, 0, '0, 32'h0, 1, 0, 32'h0);
        drive("refill_req",  0, 32'h1000, 0, 1, LINE_A, 32'h0, 1, 1, 32'h1000);
        drive("refill_fill", 0, 32'h1000, 0, 0, '0, 32'h0, 1, 0, 32'h0);
        drive("rehit_1000",  0, 32'h1000, 0, 0, '0, 32'h11, 0, 0, 32'h0);

        // Fill index 1 and confirm index 0 is untouched.
        drive("idx1_miss",   0, 32'h1010, 0, 0, '0, 32'h0, 1, 0, 32'h0);
        drive("idx1_req",    0, 32'h1010, 0, 1, LINE_C, 32'h0, 1, 1, 32'h1010);
        drive("idx1_fill",   0, 32'h1010, 0, 0, '0, 32'h0, 1, 0, 32'h0);
        drive("hit_1014",    0, 32'h1014, 0, 0, '0, 32'hb2, 0, 0, 32'h0);
        drive("keep_1008",   0, 32'h1008, 0, 0, '0, 32'h33, 0, 0, 32'h0);

        // Reset in the middle of a fill, with mem_ready high during and after it.
        drive("mid_miss",    0, 32'h1020, 0, 0, '0, 32'h0, 1, 0, 32'h0);
        drive("mid_req",     0, 32'h1020, 0, 0, '0, 32'h0, 1, 1, 32'h1020);
        drive("mid_reset",   1, 32'h1020, 0, 1, JUNK, 32'h0, 1, 0, 32'h0);
        drive("post_reset",  0, 32'h1020, 0, 1, JUNK, 32'h0, 1, 0, 32'h0);
        drive("post_req",    0, 32'h1020, 0, 0, '0, 32'h0, 1, 1, 32'h1020);
        drive("post_ready",  0, 32'h1020, 0, 1, LINE_D, 32'h0, 1, 1, 32'h1020);
        drive("post_fill",   0, 32'h1020, 0, 0, '0, 32'h0, 1, 0, 32'h0);
        drive("hit_1028",    0, 32'h1028, 0, 0, '0, 32'hc3, 0, 0, 32'h0);
        drive("cleared_1000",0, 32'h1000, 0, 0, '0, 32'h0, 1, 0, 32'h0);

        @(posedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_fetch.md
ICACHE_FETCH -- requirements
Module: icache_fetch

Interface
REQ-001 Parameters: ADDRESS_SIZE, default 32, address/instruction width.
REQ-002 Parameter: BOOT_ADDRESS, default 32'h1000, first fetch address; documentation only, no reset-state effect.
REQ-003 Parameter: LINES, default 4, number of direct-mapped lines (power of two).
REQ-004 Parameter: LINE_WORDS, default 4, 32-bit words per line (power of two).
REQ-005 Ports, name direction width meaning:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc  in  ADDRESS_SIZE  fetch address, word aligned.
- I_stall_in  in  1  downstream decode stall.
- I_instruction  out  ADDRESS_SIZE  fetched instruction.
- I_stall  out  1  fetch not delivering; PC register must hold.
- mem_req  out  1  line fill request.
- mem_addr  out  ADDRESS_SIZE  line-aligned fill address.
- mem_ready  in  1  one-cycle pulse; mem_data valid this cycle.
- mem_data  in  32*LINE_WORDS  fill line, word k at bits [32k+31:32k].

Function
REQ-006 Address split: word = pc[log2(LINE_WORDS)+1:2]; index = next log2(LINES) bits; tag = remaining upper bits.
REQ-007 Storage per line: valid bit, tag, LINE_WORDS data words.
REQ-008 States: IDLE, REQ, FILL.
REQ-009 Hit = state IDLE AND valid[index] AND tag match; combinational from pc, zero-cycle latency.
REQ-010 On hit: I_instruction = data[index][word]; I_stall = I_stall_in.
REQ-011 No hit: I_instruction = 32'h0; I_stall = 1 regardless of I_stall_in.
REQ-012 IDLE with miss: next state REQ; latch miss_addr = pc with word and byte bits zeroed. Miss detection proceeds even when I_stall_in = 1.
REQ-013 REQ: mem_req = 1 and mem_addr = miss_addr every cycle until mem_ready. mem_req = 0 and mem_addr = 0 in all other states.
REQ-014 REQ with mem_ready = 1: same edge writes mem_data into line index(miss_addr), writes tag(miss_addr), sets valid, and moves to FILL.
REQ-015 FILL: one cycle, I_stall = 1, then IDLE; lookup re-evaluates the current pc.
REQ-016 pc is guaranteed stable while I_stall = 1. If it changes in REQ, the fill still completes for the latched miss_addr, and the new pc is looked up in IDLE.
REQ-017 mem_ready in IDLE or FILL is ignored; no state or array change.
REQ-018 A fill replaces the indexed line unconditionally (direct-mapped eviction); other lines are untouched.
REQ-019 Instruction memory is read-only; no invalidate port.
REQ-020 Minimum miss penalty is 3 cycles with mem_ready in the first REQ cycle: REQ, FILL, hit.

Reset
REQ-021 reset asserted: all valid bits clear; state IDLE; mem_req 0; mem_addr 0; miss_addr 0; I_stall 1 and I_instruction 0 (combinational, no hit).
REQ-022 reset mid-REQ aborts the fill: mem_req drops asynchronously, and no line is written even if mem_ready is high.
REQ-023 Data and tag arrays need no reset; only valid bits gate hits.

Verification
REQ-024 Cold miss: reset released, pc=32'h1000, mem_ready pulsed 4 cycles after mem_req rises with mem_data={32'h44,32'h33,32'h22,32'h11} -> mem_addr=32'h1000 throughout REQ; the cycle after FILL gives I_instruction=32'h11, I_stall=0.
REQ-025 Line hits: after REQ-024, pc=32'h1004, 32'h1008, 32'h100C on consecutive cycles -> I_instruction 32'h22, 32'h33, 32'h44, I_stall=0, mem_req=0.
REQ-026 Conflict eviction: pc=32'h1040 (same index 0, new tag) -> miss, mem_addr=32'h1040; after fill, pc=32'h1000 misses again.
REQ-027 Downstream stall: hit at pc=32'h1004 with I_stall_in=1 -> I_stall=1, I_instruction=32'h22, no mem_req.
REQ-028 Reset mid-fill: reset pulsed in REQ, then mem_ready=1 after release -> state IDLE, no line written; pc=32'h1000 misses again.
REQ-029 Stray mem_ready: mem_ready=1 in IDLE with pc hitting -> output unchanged, array unchanged.
